// File: rtl/score_bcd_converter.sv
// Sequential double-dabble binary-to-packed-BCD converter for the score displays.
// Define SCORE_BCD_BLANK_EN to generate leading-zero blank flags.
module score_bcd_converter #(
    parameter int BIN_WIDTH = 27,
    parameter int DIGITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [BIN_WIDTH-1:0]  bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow,
    output logic [DIGITS-1:0]     blank_mask
);

    localparam int SW = 4 * (DIGITS + 1);
    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] MAX_VAL = (64'd10 ** DIGITS) - 64'd1;
    localparam logic [CW-1:0] LAST = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t               state;
    logic [BIN_WIDTH-1:0] sr;
    logic [SW-1:0]        scratch;
    logic [SW-1:0]        scr_adj;
    logic [CW-1:0]        count;
    logic                 ovf_pending;
    logic                 in_ovf;

    assign in_ovf = 64'(bin_in) > MAX_VAL;

    always_comb begin
        scr_adj = scratch;
        for (int i = 0; i <= DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                scr_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

`ifdef SCORE_BCD_BLANK_EN
    logic [DIGITS-1:0] mask_next;
    logic              seen;

    // Walk down from the top digit; everything above the first nonzero digit blanks.
    always_comb begin
        mask_next = '0;
        seen      = 1'b0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            seen         = seen | (scratch[4*i +: 4] != 4'd0);
            mask_next[i] = ~seen;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            blank_mask <= '0;
        else if (state == S_DONE)
            blank_mask <= ovf_pending ? '0 : mask_next;
    end
`else
    assign blank_mask = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            sr          <= '0;
            scratch     <= '0;
            count       <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (load) begin
                        sr          <= bin_in;
                        scratch     <= '0;
                        count       <= '0;
                        ovf_pending <= in_ovf;
                        busy        <= 1'b1;
                        state       <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    {scratch, sr} <= {scr_adj[SW-2:0], sr, 1'b0};
                    count         <= count + 1'b1;
                    if (count == LAST)
                        state <= S_DONE;
                end
                S_DONE: begin
                    bcd_out  <= ovf_pending ? {DIGITS{4'h9}}
                                            : scratch[4*DIGITS-1:0];
                    overflow <= ovf_pending;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_bcd_converter.sv
// Directed bench for score_bcd_converter: table of conversions plus
// hand-written sequences for ignored loads, back-to-back loads and reset.
module tb_score_bcd_converter;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [26:0] bin_in;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
    logic [7:0]  blank_mask;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    score_bcd_converter dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .bin_in     (bin_in),
        .busy       (busy),
        .done       (done),
        .bcd_out    (bcd_out),
        .overflow   (overflow),
        .blank_mask (blank_mask)
    );

    typedef struct {
        logic [26:0] bin;
        logic [31:0] bcd;
        logic        ovf;
        logic [7:0]  mask;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_mask(input logic [7:0] m);
`ifdef SCORE_BCD_BLANK_EN
        return m;
`else
        return (m & 8'h00);
`endif
    endfunction

    // Load is sampled at the edge between the two negedges; t0 is that edge.
    task automatic start(input logic [26:0] v, output int t0);
        @(negedge clk);
        bin_in = v;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        t0   = cyc;
    endtask

    // Waits for done, tracking busy and bcd_out stability; lat<0 on timeout.
    task automatic wait_done(input int t0, output int lat,
                             output bit busy_ok, output bit stable_ok);
        logic [31:0] prev;
        prev      = bcd_out;
        lat       = -1;
        busy_ok   = busy;
        stable_ok = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (done) begin
                lat = cyc - t0;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (bcd_out !== prev) stable_ok = 1'b0;
            @(negedge clk);
        end
    endtask

    initial begin
        int  t0, t1, lat, dcount;
        bit  bok, sok;

        vecs[0] = '{27'd12345678,  32'h12345678, 1'b0, 8'b00000000};
        vecs[1] = '{27'd99999999,  32'h99999999, 1'b0, 8'b00000000};
        vecs[2] = '{27'd100000000, 32'h99999999, 1'b1, 8'b00000000};
        vecs[3] = '{27'd305,       32'h00000305, 1'b0, 8'b11111000};
        vecs[4] = '{27'd0,         32'h00000000, 1'b0, 8'b11111110};
        vecs[5] = '{27'd134217727, 32'h99999999, 1'b1, 8'b00000000};
        vecs[6] = '{27'd9,         32'h00000009, 1'b0, 8'b11111110};
        vecs[7] = '{27'd10000000,  32'h10000000, 1'b0, 8'b00000000};

        rst    = 1'b1;
        load   = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_bcd", 64'(bcd_out), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_mask", 64'(blank_mask), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start(vecs[i].bin, t0);
            wait_done(t0, lat, bok, sok);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd28);
            chk($sformatf("v%0d_busy", i), 64'(bok), 64'd1);
            chk($sformatf("v%0d_stable", i), 64'(sok), 64'd1);
            chk($sformatf("v%0d_bcd", i), 64'(bcd_out), 64'(vecs[i].bcd));
            chk($sformatf("v%0d_ovf", i), 64'(overflow), 64'(vecs[i].ovf));
            chk($sformatf("v%0d_mask", i), 64'(blank_mask),
                64'(exp_mask(vecs[i].mask)));
            @(negedge clk);
            chk($sformatf("v%0d_pulse", i), 64'(done), 64'd0);
        end

        // Second load mid-conversion is dropped; bin_in changes are ignored.
        start(27'd42, t0);
        repeat (4) @(negedge clk);
        bin_in = 27'd7;
        load   = 1'b1;
        @(negedge clk);
        load   = 1'b0;
        bin_in = 27'd999;
        wait_done(t0, lat, bok, sok);
        chk("ign_latency", 64'(lat), 64'd28);
        chk("ign_bcd", 64'(bcd_out), 64'h42);
        dcount = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("ign_no_second_done", 64'(dcount), 64'd0);
        chk("ign_idle", 64'(busy), 64'd0);

        // Load in the done cycle is accepted.
        start(27'd305, t0);
        wait_done(t0, lat, bok, sok);
        chk("b2b_first_latency", 64'(lat), 64'd28);
        chk("b2b_first_bcd", 64'(bcd_out), 64'h305);
        bin_in = 27'd0;
        load   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        t1   = cyc;
        chk("b2b_accepted", 64'(busy), 64'd1);
        wait_done(t1, lat, bok, sok);
        chk("b2b_second_gap", 64'(cyc - t0), 64'd57);
        chk("b2b_second_bcd", 64'(bcd_out), 64'h0);
        chk("b2b_second_ovf", 64'(overflow), 64'd0);
        chk("b2b_second_mask", 64'(blank_mask),
            64'(exp_mask(8'b11111110)));

        // Give bcd_out a nonzero value before testing reset clears it.
        start(27'd305, t0);
        wait_done(t0, lat, bok, sok);
        chk("pre_rst_bcd", 64'(bcd_out), 64'h305);

        start(27'd55555, t0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_bcd", 64'(bcd_out), 64'd0);
        chk("mid_rst_mask", 64'(blank_mask), 64'd0);
        dcount = 0;
        repeat (40) begin
            if (done) dcount++;
            @(negedge clk);
        end
        chk("mid_rst_no_done", 64'(dcount), 64'd0);
        chk("mid_rst_bcd_held", 64'(bcd_out), 64'd0);

        start(27'd55555, t0);
        wait_done(t0, lat, bok, sok);
        chk("post_rst_latency", 64'(lat), 64'd28);
        chk("post_rst_bcd", 64'(bcd_out), 64'h55555);
        chk("post_rst_mask", 64'(blank_mask),
            64'(exp_mask(8'b11100000)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
